cpu_hazard_scoreboard: RTL and testbench
========================================

# cpu_hazard_scoreboard

Register-hazard scoreboard that gates the issue of decoded instructions into execute. Tracks one pending-write bit for each of the 64 architectural registers: x0–x31 at indices 0–31 and f0–f31 at indices 32–63, using the 6-bit `{fp, index}` encoding of decode's `inst_rs*`/`inst_rd`. Stalls issue on RAW hazards (a source is pending) and WAW hazards (the destination is pending). Sits between the decode output register and execute; clears bits on writeback and on pipeline flush.

## Interface
- `WB_PORTS`, default 2: number of independent writeback clear ports (integer and FPU result paths).
- `i_reset` in, 1: asynchronous, active-high reset.
- `i_clock` in, 1: single clock; all state updates on its rising edge.
- `i_issue_valid` in, 1: decode holds a new instruction (tag changed, not yet issued).
- `i_issue_rs1`, `i_issue_rs2`, `i_issue_rs3` in, 6 each: source register indices; 6'h00 means none.
- `i_issue_rd` in, 6: destination index; 6'h00 means no write.
- `o_issue_ready` out, 1: combinational; high when no hazard exists for the presented instruction.
- `i_wb_valid` in, `WB_PORTS`: per-port writeback strobe.
- `i_wb_rd` in, 6×`WB_PORTS`: per-port register being retired.
- `i_flush` in, 1: synchronous; clears all pending bits (branch mispredict or trap).
- `o_pending` out, 64: current scoreboard bitmap, for debug.
- `o_stall_cycles` out, 32: count of cycles with `i_issue_valid & !o_issue_ready`.
- `o_fault` out, 1: sticky; set by a writeback to a register that is not pending.

## Operation
- Issue fires when `i_issue_valid & o_issue_ready`.
  - On fire with `i_issue_rd != 0`: `pending[rd] <= 1`.
- Hazard condition:
  - A source is a hazard when its index != 0 and `pending[rs]`.
  - The destination is a hazard when `rd != 0` and `pending[rd]`.
  - `o_issue_ready = !(hazard_rs1 | hazard_rs2 | hazard_rs3 | hazard_rd)`.
  - `o_issue_ready` ignores `i_issue_valid`, so it is meaningful only while valid.
- Writeback: for each port p with `i_wb_valid[p]` and `i_wb_rd[p] != 0`, `pending[i_wb_rd[p]] <= 0`.
- Index 0 (x0) is never set; `pending[0]` is constant 0.
- Same-cycle update order is clear, then set. If writeback and issue target the same rd, the bit ends at 1.
- Two writeback ports hitting the same rd in one cycle: the bit is cleared once; no fault.
- Fault: a writeback to rd != 0 with `pending[rd] == 0` and no flush in the same cycle sets `o_fault`. It holds until reset.
- Flush:
  - All bits go to 0.
  - Any issue fire in the same cycle is discarded; the bit is not set.
  - Writebacks in the same cycle are ignored, including for fault checking.
- Stall counter: increments by 1 per qualifying cycle and wraps from 0xFFFFFFFF to 0. It is not cleared by flush.

## Timing
- Reset (asynchronous assert, synchronous release): `pending = 0`, `o_stall_cycles = 0`, `o_fault = 0`. `o_issue_ready` is then 1 for any instruction.
- `o_issue_ready` is purely combinational from inputs and the `pending` register; there are no registered outputs on the ready path.
- Latency:
  - Set: a bit is set on the edge at which issue fires, so a dependent instruction presented the next cycle sees it.
  - Clear: visible the cycle after the writeback edge (unless bypass is enabled, see Configuration).
- Reset mid-stall: pending is lost and decode re-issues from scratch. Upstream guarantees no in-flight writebacks after reset.

## Configuration
- `CPU_SCOREBOARD_BYPASS_EN` defined:
  - Hazard checks use `pending & ~wb_clear_mask`, where `wb_clear_mask` is built from the current-cycle `i_wb_valid`/`i_wb_rd`.
  - A consumer therefore issues in the same cycle its producer writes back; execute forwards the writeback value.
- Not defined: checks use `pending` only, giving one extra stall cycle per RAW/WAW dependency.

## Test plan
- Reset, then issue rd=5 and rs1=5 back-to-back:
  - The second instruction stalls with `o_issue_ready = 0`.
  - `i_wb_valid[0]` with rd=5 releases it the same cycle with bypass, or the next cycle without.
  - `o_stall_cycles` reads 1 with bypass, 2 without.
- FP/int separation: issue rd=6'h21 (f1), then rs1=6'h01 (x1) -> ready=1. Then rs2=6'h21 -> ready=0.
- x0: issue rd=0, then rs1=0 -> ready=1 and `o_pending == 0`.
- WAW plus same-cycle writeback:
  - Pending[7]=1; present rd=7 while port 1 writes back 7 (bypass on).
  - Issue fires; `pending[7]` stays 1; no fault.
- Flush with 10 bits pending and a concurrent issue of rd=9 -> `o_pending == 0` next cycle.
- Writeback of rd=12 while not pending -> `o_fault` = 1 next cycle and stays 1 until `i_reset`.

Source files
------------

// File: rtl/cpu_hazard_scoreboard.sv
// ============================================================================
// Module   : cpu_hazard_scoreboard
// Purpose  : 64-entry pending-write scoreboard gating decode->execute issue on
//            RAW/WAW hazards. Optional macro: CPU_SCOREBOARD_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_hazard_scoreboard #(
    parameter int WB_PORTS = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_issue_valid,
    input  logic [5:0]            i_issue_rs1,
    input  logic [5:0]            i_issue_rs2,
    input  logic [5:0]            i_issue_rs3,
    input  logic [5:0]            i_issue_rd,
    output logic                  o_issue_ready,
    input  logic [WB_PORTS-1:0]   i_wb_valid,
    input  logic [6*WB_PORTS-1:0] i_wb_rd,
    input  logic                  i_flush,
    output logic [63:0]           o_pending,
    output logic [31:0]           o_stall_cycles,
    output logic                  o_fault
);

    localparam logic [5:0] C_REG_NONE = 6'h00;

    logic [63:0] r_pending;
    logic [31:0] r_stall_cycles;
    logic        r_fault;

    logic [63:0] w_wb_clear_mask;
    logic        w_wb_unpending;
    logic [63:0] w_hazard_view;
    logic        w_hazard_rs1;
    logic        w_hazard_rs2;
    logic        w_hazard_rs3;
    logic        w_hazard_rd;
    logic        w_issue_fire;
    logic [63:0] w_set_mask;
    logic [63:0] w_pending_next;

    // Writeback clear mask, plus detection of a retire to a non-pending register.
    always_comb begin
        w_wb_clear_mask = 64'd0;
        w_wb_unpending  = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (i_wb_valid[p] && (i_wb_rd[p*6 +: 6] != C_REG_NONE)) begin
                w_wb_clear_mask[i_wb_rd[p*6 +: 6]] = 1'b1;
                if (!r_pending[i_wb_rd[p*6 +: 6]]) begin
                    w_wb_unpending = 1'b1;
                end
            end
        end
    end

`ifdef CPU_SCOREBOARD_BYPASS_EN
    // Producer retiring this cycle no longer blocks its consumer; execute forwards.
    assign w_hazard_view = r_pending & ~w_wb_clear_mask;
`else
    assign w_hazard_view = r_pending;
`endif

    assign w_hazard_rs1 = (i_issue_rs1 != C_REG_NONE) && w_hazard_view[i_issue_rs1];
    assign w_hazard_rs2 = (i_issue_rs2 != C_REG_NONE) && w_hazard_view[i_issue_rs2];
    assign w_hazard_rs3 = (i_issue_rs3 != C_REG_NONE) && w_hazard_view[i_issue_rs3];
    assign w_hazard_rd  = (i_issue_rd  != C_REG_NONE) && w_hazard_view[i_issue_rd];

    assign o_issue_ready = !(w_hazard_rs1 | w_hazard_rs2 | w_hazard_rs3 | w_hazard_rd);
    assign w_issue_fire  = i_issue_valid & o_issue_ready;

    always_comb begin
        w_set_mask = 64'd0;
        if (w_issue_fire && (i_issue_rd != C_REG_NONE)) begin
            w_set_mask[i_issue_rd] = 1'b1;
        end
    end

    // Clear before set, so a same-cycle retire and reissue of rd leaves it pending.
    always_comb begin
        w_pending_next = 64'd0;
        if (!i_flush) begin
            w_pending_next = (r_pending & ~w_wb_clear_mask) | w_set_mask;
        end
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pending      <= 64'd0;
            r_stall_cycles <= 32'd0;
            r_fault        <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            if (i_issue_valid && !o_issue_ready) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_wb_unpending && !i_flush) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign o_pending      = r_pending;
    assign o_stall_cycles = r_stall_cycles;
    assign o_fault        = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_cpu_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_cpu_hazard_scoreboard
// Purpose  : Directed self-checking bench for cpu_hazard_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_hazard_scoreboard;

`ifdef CPU_SCOREBOARD_BYPASS_EN
    localparam bit C_BYP = 1'b1;
`else
    localparam bit C_BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [5:0]  issue_rs1;
    logic [5:0]  issue_rs2;
    logic [5:0]  issue_rs3;
    logic [5:0]  issue_rd;
    logic        issue_ready;
    logic [1:0]  wb_valid;
    logic [11:0] wb_rd;
    logic        flush;
    logic [63:0] pending;
    logic [31:0] stall_cycles;
    logic        fault;

    int checks;
    int failures;

    cpu_hazard_scoreboard #(.WB_PORTS(2)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_issue_valid  (issue_valid),
        .i_issue_rs1    (issue_rs1),
        .i_issue_rs2    (issue_rs2),
        .i_issue_rs3    (issue_rs3),
        .i_issue_rd     (issue_rd),
        .o_issue_ready  (issue_ready),
        .i_wb_valid     (wb_valid),
        .i_wb_rd        (wb_rd),
        .i_flush        (flush),
        .o_pending      (pending),
        .o_stall_cycles (stall_cycles),
        .o_fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, leaving time to drive and settle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic present(input logic v, input logic [5:0] s1, input logic [5:0] s2,
                           input logic [5:0] s3, input logic [5:0] d);
        issue_valid = v;
        issue_rs1   = s1;
        issue_rs2   = s2;
        issue_rs3   = s3;
        issue_rd    = d;
    endtask

    initial begin
        logic [5:0]  regs [10];
        logic [63:0] exp_mask;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        wb_valid = 2'b00;
        wb_rd    = 12'd0;
        present(1'b1, 6'd5, 6'd0, 6'd0, 6'd5);

        // Reset state
        tick();
        tick();
        #1;
        check("reset_pending", pending, 64'd0);
        check("reset_stall", {32'd0, stall_cycles}, 64'd0);
        check("reset_fault", {63'd0, fault}, 64'd0);
        check("reset_ready", {63'd0, issue_ready}, 64'd1);
        rst = 1'b0;
        present(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);

        // RAW on x5 released by writeback
        tick();
        present(1'b1, 6'd0, 6'd0, 6'd0, 6'd5);
        #1;
        check("raw_producer_ready", {63'd0, issue_ready}, 64'd1);
        tick();
        present(1'b1, 6'd5, 6'd0, 6'd0, 6'd0);
        #1;
        check("raw_pending_set", pending, 64'd1 << 5);
        check("raw_consumer_stall", {63'd0, issue_ready}, 64'd0);
        tick();
        wb_valid = 2'b01;
        wb_rd    = {6'd0, 6'd5};
        #1;
        check("raw_wb_same_cycle_ready", {63'd0, issue_ready}, {63'd0, C_BYP});
        tick();
        wb_valid = 2'b00;
        wb_rd    = 12'd0;
        #1;
        check("raw_ready_after_wb", {63'd0, issue_ready}, 64'd1);
        check("raw_stall_count", {32'd0, stall_cycles}, C_BYP ? 64'd1 : 64'd2);
        check("raw_pending_clear", pending, 64'd0);
        tick();
        present(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);

        // FP/int separation: f1 pending must not block x1
        tick();
        present(1'b1, 6'd0, 6'd0, 6'd0, 6'h21);
        tick();
        present(1'b1, 6'h01, 6'd0, 6'd0, 6'd0);
        #1;
        check("fp_pending_f1", pending, 64'd1 << 33);
        check("fp_x1_ready", {63'd0, issue_ready}, 64'd1);
        present(1'b1, 6'd0, 6'h21, 6'd0, 6'd0);
        #1;
        check("fp_f1_rs2_stall", {63'd0, issue_ready}, 64'd0);
        present(1'b1, 6'd0, 6'd0, 6'h21, 6'd0);
        #1;
        check("fp_f1_rs3_stall", {63'd0, issue_ready}, 64'd0);
        present(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        wb_valid = 2'b10;
        wb_rd    = {6'h21, 6'd0};
        tick();
        wb_valid = 2'b00;
        wb_rd    = 12'd0;
        #1;
        check("fp_wb_port1_clear", pending, 64'd0);

        // x0 is never tracked
        present(1'b1, 6'd0, 6'd0, 6'd0, 6'd0);
        tick();
        #1;
        check("x0_pending", pending, 64'd0);
        check("x0_ready", {63'd0, issue_ready}, 64'd1);
        present(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);

        // WAW on x7 with same-cycle writeback on port 1
        present(1'b1, 6'd0, 6'd0, 6'd0, 6'd7);
        tick();
        #1;
        check("waw_pending7", pending, 64'd1 << 7);
        check("waw_rd_stall", {63'd0, issue_ready}, 64'd0);
        wb_valid = 2'b10;
        wb_rd    = {6'd7, 6'd0};
        #1;
        check("waw_wb_ready", {63'd0, issue_ready}, {63'd0, C_BYP});
        tick();
        wb_valid = 2'b00;
        wb_rd    = 12'd0;
        #1;
        check("waw_after_wb_ready", {63'd0, issue_ready}, {63'd0, ~C_BYP});
        tick();
        present(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        #1;
        check("waw_pending_kept", pending, 64'd1 << 7);
        check("waw_no_fault", {63'd0, fault}, 64'd0);
        check("waw_stall_count", {32'd0, stall_cycles}, C_BYP ? 64'd2 : 64'd3);

        // Both ports retire x7 together: one clear, no fault
        wb_valid = 2'b11;
        wb_rd    = {6'd7, 6'd7};
        tick();
        wb_valid = 2'b00;
        wb_rd    = 12'd0;
        #1;
        check("dual_wb_clear", pending, 64'd0);
        check("dual_wb_no_fault", {63'd0, fault}, 64'd0);

        // Flush with ten pending bits, concurrent issue and stray writeback
        regs[0] = 6'd1;  regs[1] = 6'd2;  regs[2] = 6'd3;  regs[3] = 6'd4;
        regs[4] = 6'd10; regs[5] = 6'd11; regs[6] = 6'd33; regs[7] = 6'd40;
        regs[8] = 6'd50; regs[9] = 6'd63;
        exp_mask = 64'd0;
        for (int i = 0; i < 10; i++) begin
            present(1'b1, 6'd0, 6'd0, 6'd0, regs[i]);
            exp_mask[regs[i]] = 1'b1;
            tick();
        end
        present(1'b1, 6'd0, 6'd0, 6'd0, 6'd9);
        flush    = 1'b1;
        wb_valid = 2'b01;
        wb_rd    = {6'd0, 6'd12};
        #1;
        check("flush_pre_pending", pending, exp_mask);
        check("flush_issue_ready", {63'd0, issue_ready}, 64'd1);
        tick();
        present(1'b0, 6'd0, 6'd0, 6'd0, 6'd0);
        flush    = 1'b0;
        wb_valid = 2'b00;
        wb_rd    = 12'd0;
        #1;
        check("flush_pending_zero", pending, 64'd0);
        check("flush_wb_no_fault", {63'd0, fault}, 64'd0);
        check("flush_keeps_stall", {32'd0, stall_cycles}, C_BYP ? 64'd2 : 64'd3);

        // Writeback to non-pending x12 sets a sticky fault
        wb_valid = 2'b01;
        wb_rd    = {6'd0, 6'd12};
        #1;
        check("fault_before_edge", {63'd0, fault}, 64'd0);
        tick();
        wb_valid = 2'b00;
        wb_rd    = 12'd0;
        #1;
        check("fault_set", {63'd0, fault}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        #1;
        check("fault_sticky", {63'd0, fault}, 64'd1);

        // Asynchronous reset clears everything mid-cycle
        rst = 1'b1;
        #1;
        check("async_reset_fault", {63'd0, fault}, 64'd0);
        check("async_reset_stall", {32'd0, stall_cycles}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
